// File: rtl/player_input_ctrl.sv
// Cabinet button conditioning: sync, debounce, frame-aligned moves,
// and a one-shot-per-press fire FSM with frame-counted cooldown.
module player_input_ctrl #(
  parameter int debounce_cycles_p = 16,
  parameter int cooldown_frames_p = 8
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       btn_left_i,
  input  logic       btn_right_i,
  input  logic       btn_shoot_i,
  input  logic       frame_i,
  input  logic       alive_i,
  output logic       move_left_o,
  output logic       move_right_o,
  output logic       shoot_o,
  output logic       shoot_ready_o,
  output logic [3:0] shoot_state_o
);

  localparam int DW = $clog2(debounce_cycles_p + 1);
  localparam int CW = $clog2(cooldown_frames_p + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(debounce_cycles_p - 1);
  localparam logic [CW-1:0] CD_LOAD = CW'(cooldown_frames_p);
  localparam logic [CW-1:0] CD_ONE  = CW'(1);

  typedef enum logic [3:0] {
    READY    = 4'b0001,
    FIRE     = 4'b0010,
    COOLDOWN = 4'b0100,
    HOLD     = 4'b1000
  } shoot_state_t;

  logic [2:0]    raw;
  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [2:0]    stable;
  logic [DW-1:0] db_cnt [3];

  logic left_s;
  logic right_s;
  logic shoot_s;

  shoot_state_t  state;
  logic [CW-1:0] cd_cnt;

  assign raw     = {btn_shoot_i, btn_right_i, btn_left_i};
  assign left_s  = stable[0];
  assign right_s = stable[1];
  assign shoot_s = stable[2];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Stable level flips on the cycle the mismatch run would hit the limit.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      stable <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          stable[i] <= ~stable[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      move_left_o  <= 1'b0;
      move_right_o <= 1'b0;
    end else begin
      move_left_o  <= frame_i & left_s & ~right_s & alive_i;
      move_right_o <= frame_i & right_s & ~left_s & alive_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state  <= READY;
      cd_cnt <= '0;
    end else begin
      case (state)
        READY: begin
          if (shoot_s) state <= FIRE;
        end
        FIRE: begin
          cd_cnt <= CD_LOAD;
          state  <= COOLDOWN;
        end
        COOLDOWN: begin
          if (frame_i) begin
            cd_cnt <= cd_cnt - 1'b1;
            if (cd_cnt == CD_ONE) state <= HOLD;
          end
        end
        HOLD: begin
          if (!shoot_s) state <= READY;
        end
        default: state <= READY;
      endcase
      // A dead player parks the FSM regardless of where it was heading.
      if (!alive_i) state <= HOLD;
    end
  end

  assign shoot_o       = (state == FIRE);
  assign shoot_ready_o = (state == READY);
  assign shoot_state_o = state;

endmodule

// File: tb/tb_player_input_ctrl.sv
// Scoreboard bench for player_input_ctrl: a frame-level reference
// model queues expected outputs; a monitor pops and compares.
module tb_player_input_ctrl;

  localparam int DB = 4;
  localparam int CD = 8;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic       btn_left_i = 1'b0;
  logic       btn_right_i = 1'b0;
  logic       btn_shoot_i = 1'b0;
  logic       frame_i = 1'b0;
  logic       alive_i = 1'b1;
  logic       move_left_o;
  logic       move_right_o;
  logic       shoot_o;
  logic       shoot_ready_o;
  logic [3:0] shoot_state_o;

  always #5 clk = ~clk;

  player_input_ctrl #(
    .debounce_cycles_p(DB),
    .cooldown_frames_p(CD)
  ) dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .btn_left_i(btn_left_i),
    .btn_right_i(btn_right_i),
    .btn_shoot_i(btn_shoot_i),
    .frame_i(frame_i),
    .alive_i(alive_i),
    .move_left_o(move_left_o),
    .move_right_o(move_right_o),
    .shoot_o(shoot_o),
    .shoot_ready_o(shoot_ready_o),
    .shoot_state_o(shoot_state_o)
  );

  typedef struct packed {
    logic       ml;
    logic       mr;
    logic       sh;
    logic       rdy;
    logic [3:0] st;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   n_shoot = 0;
  int   n_left = 0;
  int   n_right = 0;
  int   last_shoot_cyc = -1;
  bit   periodic = 1'b1;

  // Reference model: raw samples per button, newest in bit 0.
  logic [31:0] hist [3];
  bit          stab [3];
  int          mode;
  int          frames_since_fire;

  task automatic check(string name, logic [31:0] act, logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, want);
    end
  endtask

  task automatic model_step();
    exp_t e;
    bit   raw [3];
    bit   all_diff;
    raw[0] = btn_left_i;
    raw[1] = btn_right_i;
    raw[2] = btn_shoot_i;
    if (reset_i) begin
      for (int i = 0; i < 3; i++) begin
        hist[i] = '0;
        stab[i] = 1'b0;
      end
      mode = 0;
      frames_since_fire = 0;
      e.ml = 1'b0;
      e.mr = 1'b0;
      e.sh = 1'b0;
      e.rdy = 1'b1;
      e.st = 4'b0001;
    end else begin
      e.ml = frame_i && stab[0] && !stab[1] && alive_i;
      e.mr = frame_i && stab[1] && !stab[0] && alive_i;
      // mode: 0 ready, 1 fire, 2 cooling, 3 waiting for release
      case (mode)
        0: if (stab[2]) mode = 1;
        1: begin
          mode = 2;
          frames_since_fire = 0;
        end
        2: if (frame_i) begin
          frames_since_fire++;
          if (frames_since_fire == CD) mode = 3;
        end
        default: if (!stab[2]) mode = 0;
      endcase
      if (!alive_i) mode = 3;
      e.sh = (mode == 1);
      e.rdy = (mode == 0);
      e.st = 4'(1 << mode);
      // Level flips once the D samples taken 2..D+1 edges ago all disagree.
      for (int i = 0; i < 3; i++) begin
        hist[i] = {hist[i][30:0], raw[i]};
        all_diff = 1'b1;
        for (int j = 2; j < DB + 2; j++)
          if (hist[i][j] == stab[i]) all_diff = 1'b0;
        if (all_diff) stab[i] = !stab[i];
      end
    end
    expq.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL queue_empty cyc=%0d got=0 want=1", cyc);
      end else begin
        e = expq.pop_front();
        if (reset_i) begin
          e.ml = 1'b0;
          e.mr = 1'b0;
          e.sh = 1'b0;
          e.rdy = 1'b1;
          e.st = 4'b0001;
        end
        check("move_left", 32'(move_left_o), 32'(e.ml));
        check("move_right", 32'(move_right_o), 32'(e.mr));
        check("shoot", 32'(shoot_o), 32'(e.sh));
        check("shoot_ready", 32'(shoot_ready_o), 32'(e.rdy));
        check("shoot_state", 32'(shoot_state_o), 32'(e.st));
        check("onehot", $countones(shoot_state_o), 1);
        check("no_both", 32'(move_left_o & move_right_o), 0);
      end
      if (shoot_o) begin
        n_shoot++;
        last_shoot_cyc = cyc;
      end
      if (move_left_o) n_left++;
      if (move_right_o) n_right++;
    end
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      cyc++;
      frame_i = periodic ? (cyc % 10 == 0) : ($urandom_range(7) == 0);
    end
  endtask

  task automatic stimulus();
    int s0;
    int t0;
    int l0;
    int r0;
    int r;
    tick(3);
    reset_i = 1'b0;
    tick(20);

    s0 = n_shoot;
    t0 = cyc;
    btn_shoot_i = 1'b1;
    tick(100);
    check("shot_count", n_shoot - s0, 1);
    check("shot_latency", last_shoot_cyc - t0, 7);
    check("hold_after_cd", 32'(shoot_state_o), 32'h8);
    btn_shoot_i = 1'b0;
    tick(15);
    check("rearm_ready", 32'(shoot_state_o), 32'h1);

    l0 = n_left;
    for (int i = 0; i < 6; i++) begin
      btn_left_i = 1'b1;
      tick(3);
      btn_left_i = 1'b0;
      tick(3);
    end
    tick(10);
    check("bounce_moves", n_left - l0, 0);
    l0 = n_left;
    btn_left_i = 1'b1;
    tick(60);
    check("hold_moves_ge4", 32'(n_left - l0 >= 4), 1);

    btn_right_i = 1'b1;
    tick(10);
    l0 = n_left;
    r0 = n_right;
    tick(40);
    check("both_left", n_left - l0, 0);
    check("both_right", n_right - r0, 0);
    btn_right_i = 1'b0;
    l0 = n_left;
    tick(40);
    check("resume_left_ge3", 32'(n_left - l0 >= 3), 1);
    btn_left_i = 1'b0;
    tick(20);

    alive_i = 1'b0;
    tick(2);
    btn_shoot_i = 1'b1;
    s0 = n_shoot;
    tick(20);
    check("dead_no_shot", n_shoot - s0, 0);
    check("dead_hold", 32'(shoot_state_o), 32'h8);
    btn_shoot_i = 1'b0;
    tick(10);
    alive_i = 1'b1;
    tick(3);
    check("revive_ready", 32'(shoot_state_o), 32'h1);

    s0 = n_shoot;
    btn_shoot_i = 1'b1;
    for (int i = 0; i < 30 && n_shoot == s0; i++) tick(1);
    check("fire_seen", n_shoot - s0, 1);
    tick(25);
    check("in_cooldown", 32'(shoot_state_o), 32'h4);
    reset_i = 1'b1;
    #1;
    check("reset_state", 32'(shoot_state_o), 32'h1);
    check("reset_ready", 32'(shoot_ready_o), 1);
    tick(2);
    reset_i = 1'b0;
    s0 = n_shoot;
    tick(20);
    check("post_reset_shot", n_shoot - s0, 1);
    btn_shoot_i = 1'b0;
    tick(100);

    periodic = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(99);
      if (r < 4) btn_left_i = ~btn_left_i;
      else if (r < 8) btn_right_i = ~btn_right_i;
      else if (r < 13) btn_shoot_i = ~btn_shoot_i;
      else if (r == 13 || (r < 30 && !alive_i)) alive_i = ~alive_i;
      tick(1);
    end
    btn_left_i = 1'b0;
    btn_right_i = 1'b0;
    btn_shoot_i = 1'b0;
    alive_i = 1'b1;
    tick(10);
  endtask

  initial begin
    fork
      forever begin
        @(posedge clk);
        model_step();
      end
      monitor();
      stimulus();
    join_any
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/player_input_ctrl.md
# player_input_ctrl

Conditions the raw cabinet buttons into the per-frame command strobes consumed by `player` (`move_left_i`, `move_right_i`, `shoot_i`). It synchronises and debounces each button and aligns movement to the frame strobe. A one-hot shoot state machine enforces one shot per press plus a frame-counted cooldown. It sits between the board button pins and `player`, and shares `frame_i` with it.

## Interface
- `debounce_cycles_p`, default 16: consecutive stable synchronised cycles required before a button's debounced level changes; must be ≥1.
- `cooldown_frames_p`, default 8: number of `frame_i` strobes that must elapse after a shot before the next shot is accepted; must be ≥1.

- `clk_i` in 1: the single clock.
- `reset_i` in 1: asynchronous, active-high reset.
- `btn_left_i` in 1: raw, asynchronous left button, active-high.
- `btn_right_i` in 1: raw, asynchronous right button, active-high.
- `btn_shoot_i` in 1: raw, asynchronous shoot button, active-high.
- `frame_i` in 1: one-cycle strobe per video frame.
- `alive_i` in 1: the `alive_o` output of `player`.
- `move_left_o` out 1: one-cycle move-left command.
- `move_right_o` out 1: one-cycle move-right command.
- `shoot_o` out 1: one-cycle fire command.
- `shoot_ready_o` out 1: high while the shoot FSM is in READY.
- `shoot_state_o` out 4: one-hot shoot FSM state, bit order {HOLD, COOLDOWN, FIRE, READY}.

## Operation
- **Synchroniser:** a 2-flop synchroniser per button; flops reset to 0.
- **Debounce:** one counter and one stable level per button.
  - The counter counts cycles in which the synchronised value differs from the stable level.
  - The counter clears on any cycle in which the two match.
  - When the counter reaches `debounce_cycles_p`, the stable level flips and the counter clears.
  - Counter width is `$clog2(debounce_cycles_p+1)`. Stable levels reset to 0.
- **Movement:** all terms below are registered.
  - `move_left_o` <= `frame_i & L & ~R & alive_i`, where L and R are the stable left and right levels.
  - `move_right_o` is the mirror: `frame_i & R & ~L & alive_i`.
  - If both buttons are held, neither output asserts. Outside the cycle following `frame_i`, both outputs are 0.
- **Shoot FSM:** one-hot states READY, FIRE, COOLDOWN, HOLD. A reset or a next-state encoding that is not one-hot forces READY.
  - READY: if stable shoot = 1 and `alive_i` = 1, go to FIRE; otherwise stay.
  - FIRE: always lasts exactly one cycle. Load the cooldown counter with `cooldown_frames_p` and go to COOLDOWN.
  - COOLDOWN: the counter decrements on each `frame_i`. On a `frame_i` with counter = 1, go to HOLD.
  - HOLD: when stable shoot = 0 and `alive_i` = 1, go to READY.
  - Whenever `alive_i` = 0, next state is HOLD from every state. This overrides every transition above, including READY→FIRE.
  - Consequence: holding the button never refires. Presses made during COOLDOWN are discarded. Each shot requires a release.
- `shoot_o` = (state == FIRE). `shoot_ready_o` = (state == READY). Both are decoded from registered state.
- The cooldown counter width is `$clog2(cooldown_frames_p+1)` and it resets to 0. It never wraps, because it is only decremented while ≥1.

## Timing
- **Reset values:** all outputs are 0 except `shoot_ready_o` = 1 and `shoot_state_o` = 4'b0001. All internal counters and levels are 0.
- **Debounce latency:** a clean raw transition just before edge k appears on the stable level after edge k+1+`debounce_cycles_p`. That is 2 + `debounce_cycles_p` cycles.
- **Shoot latency:** `shoot_o` is high in the cycle after the stable shoot level rises, provided the FSM is in READY and `alive_i` = 1. It stays high for exactly 1 cycle.
- **Move latency:** the move output is high in the single cycle after a `frame_i` cycle.
- **Re-arm:** exactly `cooldown_frames_p` `frame_i` strobes after FIRE, the FSM enters HOLD. If the button is already released, READY follows one cycle later.
- **Bounce:** a glitch shorter than `debounce_cycles_p` cycles never changes the stable level.
- **`frame_i` and FIRE together:** a `frame_i` in the FIRE cycle does not count toward the cooldown.
- **Reset mid-operation:** asynchronous return to reset values. A button still held when reset releases produces a fresh debounced rise and a single shot.

## Test plan
- **Reset:** assert `reset_i` mid-cooldown → next sample shows `shoot_state_o` = 0001, all strobes 0, `shoot_ready_o` = 1.
- **Single shot:** `debounce_cycles_p` = 4, raise `btn_shoot_i` and hold for 100 cycles with `frame_i` every 10 cycles → exactly one `shoot_o` pulse, 7 cycles after the raw edge. State HOLD is reached after 8 frames.
- **Bounce rejection:** toggle `btn_left_i` with 3-cycle pulses (`debounce_cycles_p` = 4) → no `move_left_o`. Then hold it for 60 cycles with `frame_i` every 10 cycles → one `move_left_o` pulse per frame once debounced.
- **Both directions:** hold left and right together → `move_left_o` = `move_right_o` = 0 on every frame. Release right → `move_left_o` resumes after debounce.
- **Dead player:** drop `alive_i` while in READY and press shoot → no `shoot_o`, state HOLD. Raise `alive_i` with the button released → READY.
- **Continuous check:** every cycle `$countones(shoot_state_o)` = 1, and `move_left_o & move_right_o` = 0.
